instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit.sv | 130 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: addresses the instruction file, registers the word, hands it to the decoder.
// Latency: START -> INSTR_VALID next cycle from IDLE, two cycles from HALT; 1 instr/cycle sustained.
// Backpressure: INSTR_READY low holds INSTR/INSTR_PC/PC stable; no new fetch until a transfer.
module instr_fetch_unit #(
   parameter int       N          = 512,
   parameter int       PROG_DEPTH = 17,
   parameter logic [2:0] OP_STOP  = 3'b110,
   parameter int       AW         = $clog2(N)
) (
   input  logic          CLK,
   input  logic          RSTN,
   input  logic          START,
   output logic [AW-1:0] PC_AXI,
   input  logic [31:0]   INSTR_AXI,
   output logic [31:0]   INSTR,
   output logic          INSTR_VALID,
   input  logic          INSTR_READY,
   output logic [AW-1:0] INSTR_PC,
   output logic          BUSY,
   output logic          DONE,
   output logic          ERR
);

   // PC carries one extra bit so it can sit at PROG_DEPTH even when PROG_DEPTH == N.
   localparam logic [AW:0] LAST_PC = (AW+1)'(PROG_DEPTH);
   localparam logic [AW:0] PC_ONE  = (AW+1)'(1);

   // RESTART is the extra cycle after a HALT restart where PC has just been zeroed
   // and word 0 is captured on the following edge.
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_VALID   = 2'd1,
      S_HALT    = 2'd2,
      S_RESTART = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [AW:0]     pc_q, pc_d;
   logic [31:0]     instr_q, instr_d;
   logic [AW-1:0]   instr_pc_q, instr_pc_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic            fetch;
   logic            xfer;

   assign xfer = (state_q == S_VALID) && INSTR_READY;

   // Next-state logic: sequencing, STOP/runaway detection and the capture of a new word.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      done_d     = done_q;
      err_d      = err_q;
      fetch      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (START) begin
               fetch   = 1'b1;
               done_d  = 1'b0;
               err_d   = 1'b0;
               state_d = S_VALID;
            end
         end
         S_VALID: begin
            if (xfer) begin
               if (instr_q[2:0] == OP_STOP) begin
                  done_d  = 1'b1;
                  state_d = S_HALT;
               end else if (pc_q == LAST_PC) begin
                  // Ran off the populated program without a STOP.
                  err_d   = 1'b1;
                  state_d = S_HALT;
               end else begin
                  fetch = 1'b1;
               end
            end
         end
         S_HALT: begin
            if (START) begin
               pc_d    = '0;
               done_d  = 1'b0;
               err_d   = 1'b0;
               state_d = S_RESTART;
            end
         end
         S_RESTART: begin
            fetch   = 1'b1;
            state_d = S_VALID;
         end
         default: state_d = S_IDLE;
      endcase

      if (fetch) begin
         instr_d    = INSTR_AXI;
         instr_pc_d = pc_q[AW-1:0];
         pc_d       = pc_q + PC_ONE;
      end
   end

   // State and datapath registers; reset discards any held instruction immediately.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q    <= S_IDLE;
         pc_q       <= '0;
         instr_q    <= '0;
         instr_pc_q <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign PC_AXI      = pc_q[AW-1:0];
   assign INSTR       = instr_q;
   assign INSTR_PC    = instr_pc_q;
   assign INSTR_VALID = (state_q == S_VALID);
   assign BUSY        = (state_q == S_VALID);
   assign DONE        = done_q;
   assign ERR         = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: normal run, restart, backpressure, runaway, mid-run reset.
// Two instances: the 17-word program and a 4-word program with no STOP.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_instr_fetch_unit;

   localparam int AW = 9;

   logic          clk = 1'b0;
   logic          rstn;
   logic          start;
   logic [AW-1:0] pc_axi;
   logic [31:0]   instr_axi;
   logic [31:0]   instr;
   logic          instr_valid;
   logic          instr_ready;
   logic [AW-1:0] instr_pc;
   logic          busy, done, err;

   logic          r_start;
   logic [AW-1:0] r_pc_axi;
   logic [31:0]   r_instr_axi;
   logic [31:0]   r_instr;
   logic          r_instr_valid;
   logic          r_instr_ready;
   logic [AW-1:0] r_instr_pc;
   logic          r_busy, r_done, r_err;

   logic [31:0] mem   [0:511];
   logic [31:0] mem_r [0:511];
   logic [31:0] prog  [0:16];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign instr_axi   = mem[pc_axi];
   assign r_instr_axi = mem_r[r_pc_axi];

   instr_fetch_unit #(.N(512), .PROG_DEPTH(17), .OP_STOP(3'b110)) dut (
      .CLK(clk), .RSTN(rstn), .START(start), .PC_AXI(pc_axi), .INSTR_AXI(instr_axi),
      .INSTR(instr), .INSTR_VALID(instr_valid), .INSTR_READY(instr_ready),
      .INSTR_PC(instr_pc), .BUSY(busy), .DONE(done), .ERR(err)
   );

   instr_fetch_unit #(.N(512), .PROG_DEPTH(4), .OP_STOP(3'b110)) dut_r (
      .CLK(clk), .RSTN(rstn), .START(r_start), .PC_AXI(r_pc_axi), .INSTR_AXI(r_instr_axi),
      .INSTR(r_instr), .INSTR_VALID(r_instr_valid), .INSTR_READY(r_instr_ready),
      .INSTR_PC(r_instr_pc), .BUSY(r_busy), .DONE(r_done), .ERR(r_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One program run on the 17-word instance, optionally stalling at stall_pc and
   // optionally pulsing START during the stall; exp_cyc is START edge to DONE edge.
   task automatic do_run(input bit from_halt, input int stall_pc, input int stall_n,
                         input bit poke_start, input int exp_cyc);
      int cyc;
      start       = 1'b1;
      instr_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc   = 1;
      if (from_halt) begin
         chk("restart_gap_valid", 32'(instr_valid), 32'd0);
         chk("restart_done_clr", 32'(done), 32'd0);
         chk("restart_pc_axi", 32'(pc_axi), 32'd0);
         @(negedge clk);
         cyc++;
      end
      chk("run_busy", 32'(busy), 32'd1);
      for (int k = 0; k < 17; k++) begin
         chk($sformatf("run_valid_%0d", k), 32'(instr_valid), 32'd1);
         chk($sformatf("run_pc_%0d", k), 32'(instr_pc), 32'(k));
         chk($sformatf("run_word_%0d", k), instr, prog[k]);
         if (k == stall_pc) begin
            instr_ready = 1'b0;
            if (poke_start) start = 1'b1;
            for (int s = 0; s < stall_n; s++) begin
               @(negedge clk);
               start = 1'b0;
               cyc++;
               chk("stall_valid", 32'(instr_valid), 32'd1);
               chk("stall_pc", 32'(instr_pc), 32'(k));
               chk("stall_word", instr, prog[k]);
               chk("stall_pc_axi", 32'(pc_axi), 32'(k + 1));
               chk("stall_flags", {30'd0, done, err}, 32'd0);
            end
            instr_ready = 1'b1;
         end
         @(negedge clk);
         cyc++;
      end
      chk("end_valid", 32'(instr_valid), 32'd0);
      chk("end_busy", 32'(busy), 32'd0);
      chk("end_done", 32'(done), 32'd1);
      chk("end_err", 32'(err), 32'd0);
      chk("end_pc_axi", 32'(pc_axi), 32'd17);
      chk("run_cycles", 32'(cyc), 32'(exp_cyc));
   endtask

   initial begin
      for (int i = 0; i < 512; i++) begin
         mem[i]   = 32'hDEAD_BEEF;
         mem_r[i] = 32'h2000_0001 + 32'(i * 16);
      end
      prog[0] = 32'h0000_0A0A;
      for (int k = 1; k < 16; k++) prog[k] = 32'h1000_0001 | 32'(k << 8);
      prog[16] = 32'hF000_0006;
      for (int k = 0; k < 17; k++) mem[k] = prog[k];

      rstn          = 1'b1;
      start         = 1'b0;
      instr_ready   = 1'b0;
      r_start       = 1'b0;
      r_instr_ready = 1'b1;

      // Reset values
      #1 rstn = 1'b0;
      #1;
      chk("rst_pc_axi", 32'(pc_axi), 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_instr_pc", 32'(instr_pc), 32'd0);
      chk("rst_flags", {28'd0, instr_valid, busy, done, err}, 32'd0);
      chk("rst_r_flags", {28'd0, r_instr_valid, r_busy, r_done, r_err}, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      chk("idle_valid", 32'(instr_valid), 32'd0);
      chk("idle_pc_axi", 32'(pc_axi), 32'd0);

      // Runaway: 4 words, no STOP
      r_start = 1'b1;
      @(negedge clk);
      r_start = 1'b0;
      chk("rw_pc_axi_1", 32'(r_pc_axi), 32'd1);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("rw_valid_%0d", k), 32'(r_instr_valid), 32'd1);
         chk($sformatf("rw_pc_%0d", k), 32'(r_instr_pc), 32'(k));
         chk($sformatf("rw_word_%0d", k), r_instr, 32'h2000_0001 + 32'(k * 16));
         @(negedge clk);
      end
      chk("rw_valid_end", 32'(r_instr_valid), 32'd0);
      chk("rw_err", 32'(r_err), 32'd1);
      chk("rw_done", 32'(r_done), 32'd0);
      chk("rw_pc_axi", 32'(r_pc_axi), 32'd4);
      @(negedge clk);
      chk("rw_pc_axi_sat", 32'(r_pc_axi), 32'd4);
      chk("rw_err_sticky", 32'(r_err), 32'd1);

      // Full run, restart, backpressure, START during VALID
      do_run(1'b0, -1, 0, 1'b0, 18);
      do_run(1'b1, -1, 0, 1'b0, 19);
      do_run(1'b1, 5, 3, 1'b0, 22);
      do_run(1'b1, 3, 2, 1'b1, 21);

      // Reset mid-run at INSTR_PC = 8
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      repeat (8) @(negedge clk);
      chk("mid_valid", 32'(instr_valid), 32'd1);
      chk("mid_pc", 32'(instr_pc), 32'd8);
      rstn = 1'b0;
      #1;
      chk("mid_rst_pc_axi", 32'(pc_axi), 32'd0);
      chk("mid_rst_instr", instr, 32'd0);
      chk("mid_rst_instr_pc", 32'(instr_pc), 32'd0);
      chk("mid_rst_flags", {28'd0, instr_valid, busy, done, err}, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_valid", 32'(instr_valid), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_pc_axi", 32'(pc_axi), 32'd0);
      do_run(1'b0, -1, 0, 1'b0, 18);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
